seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It takes a 32-bit value (8 hex nibbles) plus a per-digit decimal-point mask, scans one digit per slot, and drives active-low anode enables and active-low segment cathodes. A guard (ghost-blank) interval blanks all digits at the start of every slot. Sits between the datapath debug/display mux (upstream, `load` strobe) and the board pins.

---
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-mux to scan-driver bundle: shadow-load strobe and payload in, board pin drives out.
// The master is the upstream display mux; the slave is the scan driver.
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        lz_en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output load, data_in, dp_in, lz_en,
    input  an, seg, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, lz_en,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode scan driver; registered outputs, new data shown from the next frame wrap.
// load is always accepted (no backpressure); the last load before a wrap wins.
module seg7_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [31:0]   act_data, act_data_nxt, shd_data;
  logic [7:0]    act_dp, act_dp_nxt, shd_dp;
  logic          act_lz, act_lz_nxt, shd_lz;
  logic          pending, pending_nxt;
  logic          slot_end, wrap;
  logic          blank_nxt, sup_nxt;
  logic [3:0]    nib;
  logic [7:0]    an_nxt, seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end = (cnt == CNT_LAST);
    wrap     = slot_end && (idx == 3'd7);
    cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
    idx_nxt  = slot_end ? idx + 3'd1 : idx;

    act_data_nxt = act_data;
    act_dp_nxt   = act_dp;
    act_lz_nxt   = act_lz;
    pending_nxt  = pending;
    // Active set only moves on the frame wrap; a load in that very cycle bypasses the shadow.
    if (wrap) begin
      pending_nxt = 1'b0;
      if (bus.load) begin
        act_data_nxt = bus.data_in;
        act_dp_nxt   = bus.dp_in;
        act_lz_nxt   = bus.lz_en;
      end else if (pending) begin
        act_data_nxt = shd_data;
        act_dp_nxt   = shd_dp;
        act_lz_nxt   = shd_lz;
      end
    end else if (bus.load) begin
      pending_nxt = 1'b1;
    end
  end

  generate
    if (BLANK == 0) begin : g_noblank
      assign blank_nxt = 1'b0;
    end else begin : g_blank
      assign blank_nxt = (cnt_nxt < CW'(BLANK));
    end
  endgenerate

  always_comb begin
    nib     = act_data_nxt[{idx_nxt, 2'b00} +: 4];
    // Digit k blanks when it and every higher nibble are zero; digit 0 always shows.
    sup_nxt = act_lz_nxt && (idx_nxt != 3'd0) &&
              ((act_data_nxt >> {idx_nxt, 2'b00}) == 32'd0);
    an_nxt  = ~(8'b1 << idx_nxt);
    seg_nxt = {~act_dp_nxt[idx_nxt], hex7(nib)};
    if (blank_nxt || sup_nxt) begin
      an_nxt  = 8'hFF;
      seg_nxt = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= 3'd0;
      act_data       <= 32'd0;
      act_dp         <= 8'd0;
      act_lz         <= 1'b0;
      shd_data       <= 32'd0;
      shd_dp         <= 8'd0;
      shd_lz         <= 1'b0;
      pending        <= 1'b0;
      bus.an         <= 8'hFF;
      bus.seg        <= 8'hFF;
      bus.frame_done <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      act_lz   <= act_lz_nxt;
      pending  <= pending_nxt;
      if (bus.load) begin
        shd_data <= bus.data_in;
        shd_dp   <= bus.dp_in;
        shd_lz   <= bus.lz_en;
      end
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: table of display words with hand-derived an/seg per digit, plus reset,
// frame-boundary, mid-frame reset and zero-guard sequences.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();
  seg7_scan_driver_if bus2 ();

  seg7_scan_driver #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  seg7_scan_driver #(.DIV(4), .BLANK(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic        lz;
    logic [63:0] an_exp;   // digit k at [8k+:8], show phase
    logic [63:0] seg_exp;
  } vec_t;

  vec_t vt [7];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    chk("frame_done_wait", {7'd0, seen}, 8'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic l);
    bus.data_in = d;
    bus.dp_in   = p;
    bus.lz_en   = l;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  initial begin
    vt[0] = '{32'h76543210, 8'h01, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'hF882_9299_B0A4_F940};
    vt[1] = '{32'h89ABCDEF, 8'h00, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'h8090_8883_C6A1_868E};
    vt[2] = '{32'h00000A05, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFB_FDFE, 64'hFFFF_FFFF_FF88_C092};
    vt[3] = '{32'h00000000, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0};
    vt[4] = '{32'h00000A05, 8'hF4, 1'b1, 64'hFFFF_FFFF_FFFB_FDFE, 64'hFFFF_FFFF_FF08_C092};
    vt[5] = '{32'h00000000, 8'hFF, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'h4040_4040_4040_4040};
    vt[6] = '{32'h80000000, 8'h00, 1'b1, 64'h7FBF_DFEF_F7FB_FDFE, 64'h80C0_C0C0_C0C0_C0C0};

    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
    bus2.load = 1'b0; bus2.data_in = '0; bus2.dp_in = '0; bus2.lz_en = 1'b0;
    rst_n = 1'b0;
    rst2_n = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_an", bus.an, 8'hFF);
      chk("rst_seg", bus.seg, 8'hFF);
      chk("rst_fd", {7'd0, bus.frame_done}, 8'd0);
    end
    rst_n = 1'b1;
    tick(1);
    chk("first_blank_an", bus.an, 8'hFF);
    tick(1);
    chk("first_show_an", bus.an, 8'hFE);
    chk("first_show_seg", bus.seg, 8'hC0);

    // Table: load, wait for the wrap, then walk one full frame.
    for (int v = 0; v < 7; v++) begin
      do_load(vt[v].data, vt[v].dp, vt[v].lz);
      wait_fd(200);
      for (int s = 0; s < 64; s++) begin
        int d, c;
        d = s / 8;
        c = s % 8;
        if (s == 0) chk("fd_high", {7'd0, bus.frame_done}, 8'd1);
        if (s == 1) chk("fd_width", {7'd0, bus.frame_done}, 8'd0);
        if (c == 0) begin
          chk("blank_an", bus.an, 8'hFF);
          chk("blank_seg", bus.seg, 8'hFF);
        end
        if (c == 5) begin
          chk($sformatf("v%0d_d%0d_an", v, d), bus.an, vt[v].an_exp[8*d +: 8]);
          chk($sformatf("v%0d_d%0d_seg", v, d), bus.seg, vt[v].seg_exp[8*d +: 8]);
        end
        tick(1);
      end
      chk("fd_period", {7'd0, bus.frame_done}, 8'd1);
    end

    // Frame boundary: mid-frame load stays hidden, a load in the wrap cycle wins.
    tick(20);
    do_load(32'h1, 8'h00, 1'b0);
    tick(39);
    chk("fb_cur_an", bus.an, 8'h7F);
    chk("fb_cur_seg", bus.seg, 8'h80);
    tick(3);
    do_load(32'hF, 8'h00, 1'b0);
    chk("fb_fd", {7'd0, bus.frame_done}, 8'd1);
    tick(5);
    chk("fb_new_an", bus.an, 8'hFE);
    chk("fb_new_seg", bus.seg, 8'h8E);
    tick(8);
    chk("fb_new_d1", bus.seg, 8'hC0);
    tick(56);
    chk("fb_next_seg", bus.seg, 8'h8E);

    // Reset mid-frame with a pending shadow load.
    tick(5);
    do_load(32'h5, 8'h00, 1'b0);
    tick(33);
    chk("mr_pre_an", bus.an, 8'hDF);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_an", bus.an, 8'hFF);
    chk("mr_async_seg", bus.seg, 8'hFF);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("mr_blank_an", bus.an, 8'hFF);
    tick(1);
    chk("mr_show_an", bus.an, 8'hFE);
    chk("mr_show_seg", bus.seg, 8'hC0);
    wait_fd(100);
    tick(5);
    chk("mr_after_wrap_an", bus.an, 8'hFE);
    chk("mr_after_wrap_seg", bus.seg, 8'hC0);

    // No guard band: every cycle after the first slot lights exactly the slot's digit.
    rst2_n = 1'b1;
    tick(4);
    for (int n = 4; n < 68; n++) begin
      logic [7:0] exp_an;
      exp_an = ~(8'b1 << ((n / 4) % 8));
      chk($sformatf("g0_an_%0d", n), bus2.an, exp_an);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
